burst_ram: RTL and testbench

BURST_RAM -- requirements
Module: burst_ram

---
 rtl/burst_ram.sv | 219 +++++++++++++++++++++
 tb/tb_burst_ram.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_ram.sv
// -----------------------------------------------------------------------------
// burst_ram
//
// Behavioural model of a burst-oriented external memory with a calibration
// phase. Words are 64 bits wide and addressed as 8-byte words. Every command
// moves BURST_LENGTH consecutive words, with addresses wrapping at the top of
// memory.
//
// Parameters
//   DEPTH_BITWIDTH            address width in 8-byte words (2^N words)
//   BURST_LENGTH              beats per command
//   CYCLES_BEFORE_DATA_VALID  edges from read accept to the first valid beat
//   CYCLES_BEFORE_INITIATED   edges from reset release to init_calib
//
// Ports
//   clk            single clock; all state changes on its rising edge
//   rst            synchronous active-high reset
//   cmd            0: read, 1: write
//   cmd_en         cmd, addr and the first wr_data beat are valid this cycle
//   addr           starting word address of the burst
//   wr_data        write beat data, one beat per cycle starting at accept
//   data_mask      accepted and ignored; all 8 bytes are always written
//   rd_data        read beat data, zero whenever rd_data_valid is low
//   rd_data_valid  rd_data holds a burst beat this cycle
//   init_calib     device is ready to accept commands
//   busy           a command is in progress; cmd_en is ignored while high
//
// Memory contents are not cleared by rst. A reset during a burst aborts it;
// beats already written stay in memory.
// -----------------------------------------------------------------------------
module burst_ram #(
  parameter int DEPTH_BITWIDTH           = 21,
  parameter int BURST_LENGTH             = 4,
  parameter int CYCLES_BEFORE_DATA_VALID = 6,
  parameter int CYCLES_BEFORE_INITIATED  = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd,
  input  logic                      cmd_en,
  input  logic [DEPTH_BITWIDTH-1:0] addr,
  input  logic [63:0]               wr_data,
  input  logic [7:0]                data_mask,
  output logic [63:0]               rd_data,
  output logic                      rd_data_valid,
  output logic                      init_calib,
  output logic                      busy
);

  localparam int DEPTH   = 1 << DEPTH_BITWIDTH;
  // One counter serves both the read latency wait and the beat count.
  localparam int CNT_MAX = (BURST_LENGTH > CYCLES_BEFORE_DATA_VALID) ?
                           BURST_LENGTH : CYCLES_BEFORE_DATA_VALID;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int INIT_W  = (CYCLES_BEFORE_INITIATED > 1) ?
                           $clog2(CYCLES_BEFORE_INITIATED + 1) : 1;

  localparam logic [CNT_W-1:0]  CNT_ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_DATA_WAIT = CNT_W'(CYCLES_BEFORE_DATA_VALID);
  localparam logic [CNT_W-1:0]  CNT_BURST     = CNT_W'(BURST_LENGTH);
  localparam logic [CNT_W-1:0]  CNT_LAST_WR   = CNT_W'(BURST_LENGTH - 1);
  localparam logic [INIT_W-1:0] INIT_LAST     = INIT_W'(CYCLES_BEFORE_INITIATED - 1);
  localparam logic [DEPTH_BITWIDTH-1:0] PTR_ONE = DEPTH_BITWIDTH'(1);

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    READ_WAIT,
    READ_BURST,
    WRITE_BURST
  } state_t;

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  state_t                    state_reg, state_next;
  logic [CNT_W-1:0]          cnt_reg, cnt_next;
  logic [DEPTH_BITWIDTH-1:0] ptr_reg, ptr_next;
  logic [INIT_W-1:0]         init_cnt_reg, init_cnt_next;
  logic                      init_calib_reg, init_calib_next;

  // Memory-side strobes produced by the FSM
  logic                      mem_we;
  logic [DEPTH_BITWIDTH-1:0] mem_waddr;
  logic                      rd_fire;

  // Storage and read output register
  logic [63:0]               mem [0:DEPTH-1];
  logic [63:0]               rd_data_reg;
  logic                      rd_valid_reg;

  // The mask has no effect on the stored word.
  logic                      unused_mask;
  assign unused_mask = ^data_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= INIT;
      cnt_reg        <= '0;
      ptr_reg        <= '0;
      init_cnt_reg   <= '0;
      init_calib_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      ptr_reg        <= ptr_next;
      init_cnt_reg   <= init_cnt_next;
      init_calib_reg <= init_calib_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    ptr_next        = ptr_reg;
    init_cnt_next   = init_cnt_reg;
    init_calib_next = init_calib_reg;
    mem_we          = 1'b0;
    mem_waddr       = ptr_reg;
    rd_fire         = 1'b0;

    case (state_reg)
      INIT: begin
        // init_cnt_reg holds the number of edges seen since reset release.
        if (init_cnt_reg >= INIT_LAST || CYCLES_BEFORE_INITIATED <= 1) begin
          state_next      = IDLE;
          init_calib_next = 1'b1;
        end else begin
          init_cnt_next = init_cnt_reg + INIT_W'(1);
        end
      end

      IDLE: begin
        if (cmd_en) begin
          if (cmd) begin
            // The first write beat lands in memory at the accept edge itself.
            mem_we     = 1'b1;
            mem_waddr  = addr;
            ptr_next   = addr + PTR_ONE;
            cnt_next   = CNT_ONE;
            state_next = (BURST_LENGTH > 1) ? WRITE_BURST : IDLE;
          end else begin
            // cnt counts edges since accept; it reads 1 at the first edge after.
            ptr_next   = addr;
            cnt_next   = CNT_ONE;
            state_next = READ_WAIT;
          end
        end
      end

      READ_WAIT: begin
        if (cnt_reg == CNT_DATA_WAIT) begin
          rd_fire    = 1'b1;
          ptr_next   = ptr_reg + PTR_ONE;
          cnt_next   = CNT_ONE;
          state_next = READ_BURST;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      READ_BURST: begin
        // cnt now counts beats already issued; once all are out, the state
        // is held through the last valid cycle and leaves on the next edge.
        if (cnt_reg == CNT_BURST) begin
          state_next = IDLE;
        end else begin
          rd_fire  = 1'b1;
          ptr_next = ptr_reg + PTR_ONE;
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      WRITE_BURST: begin
        mem_we    = 1'b1;
        mem_waddr = ptr_reg;
        ptr_next  = ptr_reg + PTR_ONE;
        cnt_next  = cnt_reg + CNT_ONE;
        if (cnt_reg == CNT_LAST_WR) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = INIT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Storage: no reset on the array, writes are blocked while rst is high so
  // an aborted burst never lands its pending beat.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[mem_waddr] <= wr_data;
    end
  end

  // Registered read port; forced to zero outside valid beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else if (rd_fire) begin
      rd_data_reg  <= mem[ptr_reg];
      rd_valid_reg <= 1'b1;
    end else begin
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end
  end

  assign rd_data       = rd_data_reg;
  assign rd_data_valid = rd_valid_reg;
  assign init_calib    = init_calib_reg;
  assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_burst_ram.sv
// -----------------------------------------------------------------------------
// tb_burst_ram
//
// Self-checking bench for burst_ram. A sparse word model (associative array,
// unwritten words read as zero) predicts read data; the expected timeline of
// each command is derived from the accept edge by plain arithmetic.
// -----------------------------------------------------------------------------
module tb_burst_ram;

  localparam int AW  = 21;
  localparam int BL  = 4;
  localparam int DV  = 6;
  localparam int INI = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd;
  logic          cmd_en;
  logic [AW-1:0] addr;
  logic [63:0]   wr_data;
  logic [7:0]    data_mask;
  logic [63:0]   rd_data;
  logic          rd_data_valid;
  logic          init_calib;
  logic          busy;

  int pass_cnt  = 0;
  int check_cnt = 0;

  logic [63:0] model [logic [AW-1:0]];

  burst_ram #(
    .DEPTH_BITWIDTH(AW),
    .BURST_LENGTH(BL),
    .CYCLES_BEFORE_DATA_VALID(DV),
    .CYCLES_BEFORE_INITIATED(INI)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd(cmd),
    .cmd_en(cmd_en),
    .addr(addr),
    .wr_data(wr_data),
    .data_mask(data_mask),
    .rd_data(rd_data),
    .rd_data_valid(rd_data_valid),
    .init_calib(init_calib),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model_rd(input logic [AW-1:0] a);
    if (model.exists(a)) return model[a];
    return 64'h0;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write burst starting now; ends just after the edge where busy drops.
  task automatic do_write(input logic [AW-1:0] a, input logic [63:0] d [BL],
                          input logic [7:0] m);
    cmd       = 1'b1;
    cmd_en    = 1'b1;
    addr      = a;
    data_mask = m;
    wr_data   = d[0];
    for (int k = 0; k < BL; k++) begin
      tick();
      cmd_en = 1'b0;
      model[a + AW'(k)] = d[k];
      check_cnt++;
      if (busy !== (k < BL - 1))
        $display("FAIL write_busy addr=%h edge=E%0d got=%b exp=%b", a, k, busy, (k < BL - 1));
      else pass_cnt++;
      if (k + 1 < BL) wr_data = d[k + 1];
    end
    wr_data = rand64();
    $display("write addr=%h data=%h %h %h %h mask=%h", a, d[0], d[1], d[2], d[3], m);
  endtask

  // Read burst starting now; checks every cycle until the FSM is idle again.
  // inject: pulse a write to 0x20 while the read is in flight.
  task automatic do_read(input logic [AW-1:0] a, input bit inject, input string tag);
    logic [63:0] exp_d;
    bit          exp_v;
    cmd    = 1'b0;
    cmd_en = 1'b1;
    addr   = a;
    tick();
    cmd_en = 1'b0;
    check_cnt++;
    if (busy !== 1'b1) $display("FAIL %s busy_at_accept got=%b exp=1", tag, busy);
    else pass_cnt++;
    for (int j = 1; j <= DV + BL + 1; j++) begin
      if (inject && (j == 2 || j == DV + 1)) begin
        cmd     = 1'b1;
        cmd_en  = 1'b1;
        addr    = AW'(32'h20);
        wr_data = rand64();
      end
      tick();
      cmd_en = 1'b0;
      exp_v  = (j >= DV) && (j < DV + BL);
      exp_d  = exp_v ? model_rd(a + AW'(j - DV)) : 64'h0;
      check_cnt++;
      if (rd_data_valid !== exp_v)
        $display("FAIL %s valid addr=%h edge=E%0d got=%b exp=%b", tag, a, j, rd_data_valid, exp_v);
      else pass_cnt++;
      check_cnt++;
      if (rd_data !== exp_d)
        $display("FAIL %s rd_data addr=%h edge=E%0d got=%h exp=%h", tag, a, j, rd_data, exp_d);
      else pass_cnt++;
      check_cnt++;
      if (busy !== (j < DV + BL))
        $display("FAIL %s busy addr=%h edge=E%0d got=%b exp=%b", tag, a, j, busy, (j < DV + BL));
      else pass_cnt++;
    end
    $display("read %s addr=%h", tag, a);
  endtask

  // Release rst and count the calibration phase.
  task automatic release_and_init(input string tag, input bit pulse_cmds);
    rst = 1'b0;
    for (int j = 1; j <= INI + 2; j++) begin
      if (pulse_cmds && j <= INI - 2) begin
        cmd    = 1'(j % 2);
        cmd_en = 1'b1;
        addr   = AW'($urandom());
      end else begin
        cmd_en = 1'b0;
      end
      tick();
      check_cnt++;
      if (init_calib !== (j >= INI))
        $display("FAIL %s init_calib edge=%0d got=%b exp=%b", tag, j, init_calib, (j >= INI));
      else pass_cnt++;
      check_cnt++;
      if (busy !== (j < INI))
        $display("FAIL %s busy edge=%0d got=%b exp=%b", tag, j, busy, (j < INI));
      else pass_cnt++;
      check_cnt++;
      if (rd_data_valid !== 1'b0)
        $display("FAIL %s valid_in_init edge=%0d got=%b exp=0", tag, j, rd_data_valid);
      else pass_cnt++;
    end
    cmd_en = 1'b0;
    $display("init %s complete", tag);
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    cmd_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_cnt++;
      if (init_calib !== 1'b0) $display("FAIL reset_init_calib got=%b exp=0", init_calib);
      else pass_cnt++;
      check_cnt++;
      if (busy !== 1'b1) $display("FAIL reset_busy got=%b exp=1", busy);
      else pass_cnt++;
      check_cnt++;
      if (rd_data_valid !== 1'b0 || rd_data !== 64'h0)
        $display("FAIL reset_rd got valid=%b data=%h exp valid=0 data=0", rd_data_valid, rd_data);
      else pass_cnt++;
    end
    release_and_init("power_up", 1'b1);
  endtask

  task automatic test_write_read();
    logic [63:0] d [BL];
    d[0] = 64'h1111_1111_1111_1111;
    d[1] = 64'h2222_2222_2222_2222;
    d[2] = 64'h3333_3333_3333_3333;
    d[3] = 64'h4444_4444_4444_4444;
    do_write(AW'(32'h10), d, 8'h00);
    do_read(AW'(32'h10), 1'b0, "basic");
  endtask

  task automatic test_wrap();
    logic [63:0] d [BL];
    for (int k = 0; k < BL; k++) d[k] = 64'hA5A5_0000_0000_0000 | 64'(k + 1) | (rand64() & 64'h0000_FFFF_FFFF_0000);
    do_write(AW'(32'h1FFFFE), d, 8'h00);
    do_read(AW'(32'h1FFFFE), 1'b0, "wrap_top");
    do_read(AW'(32'h0), 1'b0, "wrap_zero");
  endtask

  task automatic test_busy_ignore();
    logic [63:0] d [BL];
    for (int k = 0; k < BL; k++) d[k] = rand64();
    do_write(AW'(32'h20), d, 8'h00);
    do_read(AW'(32'h100), 1'b1, "busy_ignore");
    do_read(AW'(32'h20), 1'b0, "after_ignore");
  endtask

  task automatic test_mask();
    logic [63:0] d [BL];
    for (int k = 0; k < BL; k++) d[k] = rand64();
    do_write(AW'(32'h4000), d, 8'hFF);
    do_read(AW'(32'h4000), 1'b0, "mask_ff");
  endtask

  // Random writes immediately followed by reads (back-to-back with the
  // write's final edge), plus reads of earlier random locations.
  task automatic test_back_to_back();
    logic [63:0]   d [BL];
    logic [AW-1:0] a;
    logic [AW-1:0] hist [$];
    for (int i = 0; i < 6; i++) begin
      a = (i % 3 == 2) ? AW'(32'h1FFFFC + $urandom_range(0, 3)) : AW'($urandom());
      for (int k = 0; k < BL; k++) d[k] = rand64();
      do_write(a, d, 8'($urandom()));
      do_read(a, 1'b0, "rand_b2b");
      hist.push_back(a + AW'($urandom_range(0, 2)));
    end
    for (int i = 0; i < 3; i++) do_read(hist[$urandom_range(0, hist.size() - 1)], 1'b0, "rand_hist");
  endtask

  task automatic test_reset_mid_write();
    logic [63:0] d [BL];
    for (int k = 0; k < BL; k++) d[k] = rand64();
    do_write(AW'(32'h300), d, 8'h00);
    for (int k = 0; k < BL; k++) d[k] = rand64();
    cmd     = 1'b1;
    cmd_en  = 1'b1;
    addr    = AW'(32'h300);
    wr_data = d[0];
    tick();
    cmd_en  = 1'b0;
    wr_data = d[1];
    tick();
    // Beats 0 and 1 are in memory; rst at the next edge drops the rest.
    model[AW'(32'h300)] = d[0];
    model[AW'(32'h301)] = d[1];
    wr_data = d[2];
    rst     = 1'b1;
    tick();
    check_cnt++;
    if (busy !== 1'b1 || init_calib !== 1'b0)
      $display("FAIL midwrite_reset got busy=%b init_calib=%b exp busy=1 init_calib=0", busy, init_calib);
    else pass_cnt++;
    wr_data = d[3];
    tick();
    release_and_init("after_write_abort", 1'b0);
    do_read(AW'(32'h300), 1'b0, "midwrite");
  endtask

  task automatic test_reset_mid_read();
    cmd    = 1'b0;
    cmd_en = 1'b1;
    addr   = AW'(32'h10);
    tick();
    cmd_en = 1'b0;
    for (int j = 1; j <= DV + 1; j++) tick();
    check_cnt++;
    if (rd_data_valid !== 1'b1 || rd_data !== model_rd(AW'(32'h11)))
      $display("FAIL midread_beat2 got valid=%b data=%h exp valid=1 data=%h",
               rd_data_valid, rd_data, model_rd(AW'(32'h11)));
    else pass_cnt++;
    rst = 1'b1;
    tick();
    check_cnt++;
    if (rd_data_valid !== 1'b0 || rd_data !== 64'h0)
      $display("FAIL midread_abort got valid=%b data=%h exp valid=0 data=0", rd_data_valid, rd_data);
    else pass_cnt++;
    check_cnt++;
    if (init_calib !== 1'b0 || busy !== 1'b1)
      $display("FAIL midread_state got init_calib=%b busy=%b exp init_calib=0 busy=1", init_calib, busy);
    else pass_cnt++;
    tick();
    release_and_init("after_read_abort", 1'b0);
    do_read(AW'(32'h10), 1'b0, "reread");
    do_read(AW'(32'h1FFFFE), 1'b0, "reread_wrap");
  endtask

  initial begin
    rst       = 1'b1;
    cmd       = 1'b0;
    cmd_en    = 1'b0;
    addr      = '0;
    wr_data   = '0;
    data_mask = '0;
    test_reset();
    test_write_read();
    test_wrap();
    test_busy_ignore();
    test_mask();
    test_back_to_back();
    test_reset_mid_write();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
